// File: rtl/tgate_config_loader.sv
// Serial, parity-checked configuration loader for the transmission-gate fabric.
// Sole writer of the active-low gate enables; a frame is committed only after its parity bit checks out.
module tgate_config_loader #(
  parameter int NUM_GATES  = 16,
  parameter int NUM_FRAMES = 4,
  parameter int FIDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic                             cfg_abort,
  input  logic                             cfg_clear,
  input  logic                             cfg_valid,
  input  logic                             cfg_data,
  output logic                             cfg_ready,
  output logic                             cfg_busy,
  output logic                             cfg_done,
  output logic                             cfg_error,
  output logic [FIDX_W-1:0]                frame_idx,
  output logic [NUM_FRAMES*NUM_GATES-1:0]  sram_en_n
);

  localparam int CNT_W = $clog2(NUM_GATES + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(NUM_GATES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(NUM_GATES);
  localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_PARITY, S_COMMIT, S_DONE, S_ERROR
  } state_t;

  state_t                          state_q, state_d;
  logic [NUM_GATES-1:0]            shadow_q, shadow_d;
  logic [CNT_W-1:0]                bit_cnt_q, bit_cnt_d;
  logic [FIDX_W-1:0]               frame_idx_q, frame_idx_d;
  logic                            error_q, error_d;
  logic [NUM_FRAMES*NUM_GATES-1:0] sram_q, sram_d;
  logic                            xfer;

  assign xfer = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      frame_idx_q <= '0;
      error_q     <= 1'b0;
      sram_q      <= '1;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_idx_q <= frame_idx_d;
      error_q     <= error_d;
      sram_q      <= sram_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bit_cnt_d   = bit_cnt_q;
    frame_idx_d = frame_idx_q;
    error_d     = error_q;
    sram_d      = sram_q;

    // Abort beats everything, including a transfer on the same edge; committed frames are kept.
    if (state_q != S_IDLE && cfg_abort) begin
      state_d   = S_IDLE;
      shadow_d  = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            state_d     = S_SHIFT;
            frame_idx_d = '0;
            bit_cnt_d   = '0;
            shadow_d    = '0;
            error_d     = 1'b0;
          end else if (cfg_clear) begin
            sram_d = '1;
          end
        end
        S_SHIFT: begin
          if (xfer) begin
            for (int i = 0; i < NUM_GATES; i++) begin
              if (bit_cnt_q == CNT_W'(i)) shadow_d[i] = cfg_data;
            end
            bit_cnt_d = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          if (xfer) begin
            if ((^{shadow_q, cfg_data}) == 1'b0) begin
              state_d = S_COMMIT;
            end else begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end
          end
        end
        S_COMMIT: begin
          // Config bit 1 means the gate conducts, so the stored enable is inverted.
          for (int f = 0; f < NUM_FRAMES; f++) begin
            if (frame_idx_q == FIDX_W'(f)) sram_d[f*NUM_GATES +: NUM_GATES] = ~shadow_q;
          end
          if (frame_idx_q == LAST_FRAME) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_SHIFT;
            frame_idx_d = frame_idx_q + 1'b1;
            bit_cnt_d   = '0;
            shadow_d    = '0;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready = (state_q == S_SHIFT) || (state_q == S_PARITY);
    cfg_busy  = (state_q != S_IDLE);
    cfg_done  = (state_q == S_DONE);
  end

  assign cfg_error = error_q;
  assign frame_idx = frame_idx_q;
  assign sram_en_n = sram_q;

endmodule
